// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word collector.
// SERIAL_COLLECT_PARITY_EN adds the PAR state used for the trailing even-parity bit.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
`ifdef SERIAL_COLLECT_PARITY_EN
    ,
    PAR   = 2'd3
`endif
  } state_t;

  // Reduction XOR of up to 16 bits; 1 means an odd number of ones.
  function automatic logic odd_parity(input logic [15:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sc_bit_cnt.sv
// Saturating bit counter for serial_collect: synchronous clear (optionally
// reloading to one), increment, and a flag for the last data bit position.
module sc_bit_cnt #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] MAXC = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_r;

  // Count register; clear together with inc restarts a word at count 1.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_r <= ZERO;
    end else if (clr) begin
      cnt_r <= inc ? ONE : ZERO;
    end else if (inc && (cnt_r != MAXC)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == LAST);

endmodule

// File: rtl/serial_collect.sv
// Collects LSB-first serial bits into a WIDTH-bit word with valid/ready handoff.
// Define SERIAL_COLLECT_PARITY_EN to expect an even-parity bit and add Parity_err.
module serial_collect
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Sin,
  input  logic             Sin_en,
  output logic [WIDTH-1:0] Pout,
  output logic             Pout_valid,
  input  logic             Pout_ready,
  output logic             Overrun
`ifdef SERIAL_COLLECT_PARITY_EN
  ,
  output logic             Parity_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] pout_r, pout_nx_s, bit0_s;
  logic [CW-1:0]    cnt_s;
  logic             tc_s, clr_s, inc_s;
  logic             valid_r, overrun_r, overrun_nx_s;
`ifdef SERIAL_COLLECT_PARITY_EN
  logic             parity_err_r, parity_err_nx_s;
`endif

  assign bit0_s = {{(WIDTH-1){1'b0}}, Sin};

  sc_bit_cnt #(.WIDTH(WIDTH), .CW(CW)) u_bit_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (clr_s),
    .inc   (inc_s),
    .cnt   (cnt_s),
    .tc    (tc_s)
  );

  // Next-state, next-word and overrun decode.
  always_comb begin
    state_nx_s   = state_r;
    pout_nx_s    = pout_r;
    overrun_nx_s = 1'b0;
    clr_s        = 1'b0;
    inc_s        = 1'b0;
`ifdef SERIAL_COLLECT_PARITY_EN
    parity_err_nx_s = parity_err_r;
`endif
    case (state_r)
      IDLE: begin
        if (Sin_en) begin
          pout_nx_s  = bit0_s;
          inc_s      = 1'b1;
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        if (Sin_en) begin
          pout_nx_s = pout_r | (bit0_s << cnt_s);
          inc_s     = 1'b1;
          if (tc_s) begin
`ifdef SERIAL_COLLECT_PARITY_EN
            state_nx_s = PAR;
`else
            state_nx_s = FULL;
`endif
          end else begin
            state_nx_s = SHIFT;
          end
        end else begin
          state_nx_s = SHIFT;
        end
      end
`ifdef SERIAL_COLLECT_PARITY_EN
      PAR: begin
        if (Sin_en) begin
          parity_err_nx_s = odd_parity(16'(pout_r)) ^ Sin;
          state_nx_s      = FULL;
        end else begin
          state_nx_s = PAR;
        end
      end
`endif
      FULL: begin
        if (Pout_ready) begin
          clr_s = 1'b1;
`ifdef SERIAL_COLLECT_PARITY_EN
          parity_err_nx_s = 1'b0;
`endif
          // A bit arriving on the transfer edge starts the next word.
          if (Sin_en) begin
            pout_nx_s  = bit0_s;
            inc_s      = 1'b1;
            state_nx_s = SHIFT;
          end else begin
            state_nx_s = IDLE;
          end
        end else if (Sin_en) begin
          overrun_nx_s = 1'b1;
        end else begin
          state_nx_s = FULL;
        end
      end
      default: begin
        state_nx_s = IDLE;
        pout_nx_s  = {WIDTH{1'b0}};
        clr_s      = 1'b1;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= IDLE;
      pout_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
`ifdef SERIAL_COLLECT_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_nx_s;
      pout_r    <= pout_nx_s;
      valid_r   <= (state_nx_s == FULL);
      overrun_r <= overrun_nx_s;
`ifdef SERIAL_COLLECT_PARITY_EN
      parity_err_r <= parity_err_nx_s;
`endif
    end
  end

  assign Pout       = pout_r;
  assign Pout_valid = valid_r;
  assign Overrun    = overrun_r;
`ifdef SERIAL_COLLECT_PARITY_EN
  assign Parity_err = parity_err_r;
`endif

endmodule
